// File: rtl/led_arb_pkg.sv
// led_arbiter shared constants.
// State encoding and OWNER codes.
package led_arb_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GRANT1 = 2'b01;
    localparam logic [1:0] GRANT2 = 2'b10;
    localparam logic [1:0] GAP    = 2'b11;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_B1   = 2'b01;
    localparam logic [1:0] OWN_B2   = 2'b10;

endpackage

// File: rtl/button_debounce.sv
// Active-low button synchroniser and debouncer.
// Emits a one-cycle PRESS_EVT on each accepted press.
module button_debounce
    import led_arb_pkg::*;
#(
    parameter logic [14:0] DEB_MAX = 15'd24000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BUT_N,
    output logic PRESSED,
    output logic PRESS_EVT
);

    localparam int CW = $clog2(int'(DEB_MAX) + 1);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          differ, hit;

    // Count consecutive disagreeing cycles; accept on DEB_MAX.
    always_comb begin
        cnt_inc  = cnt_q + CW'(1);
        differ   = (s2_q != stable_q);
        hit      = differ && (cnt_inc == CW'(DEB_MAX));
        cnt_d    = '0;
        stable_d = stable_q;
        if (differ) begin
            if (hit) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Two-flop synchroniser, stable level and counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            s1_q     <= BUT_N;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign PRESSED   = ~stable_q;
    assign PRESS_EVT = hit & ~s2_q;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the two user LEDs.
// Debounced presses queue requests; grants hold, then gap.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter logic [14:0] DEB_MAX     = 15'd24000,
    parameter logic [23:0] HOLD_CYCLES = 24'd10000000,
    // 20 bits so the one-million default fits
    parameter logic [19:0] GAP_CYCLES  = 20'd1000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BUT1,
    input  logic       BUT2,
    output logic       LED1,
    output logic       LED2,
    output logic [1:0] OWNER,
    output logic [1:0] PEND
);

    localparam int HW = (HOLD_CYCLES > 1) ?
                        $clog2(int'(HOLD_CYCLES)) : 1;
    localparam int GW = (GAP_CYCLES > 1) ?
                        $clog2(int'(GAP_CYCLES)) : 1;

    if (GAP_CYCLES == 0) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end
    if (HOLD_CYCLES == 0) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end

    logic          evt1, evt2;
    logic [1:0]    state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          last2_q, last2_d;
    logic          idle, g1, g2;

    button_debounce #(.DEB_MAX(DEB_MAX)) u_deb1 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BUT_N     (BUT1),
        .PRESSED   (),
        .PRESS_EVT (evt1)
    );

    button_debounce #(.DEB_MAX(DEB_MAX)) u_deb2 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BUT_N     (BUT2),
        .PRESSED   (),
        .PRESS_EVT (evt2)
    );

    // Grant choice, state/counter sequencing and pending update.
    always_comb begin
        idle    = (state_q == IDLE);
        g1      = idle & pend_q[0] & (~pend_q[1] | last2_q);
        g2      = idle & pend_q[1] & (~pend_q[0] | ~last2_q);
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        last2_d = last2_q;
        unique case (state_q)
            IDLE: begin
                if (g1) begin
                    state_d = GRANT1;
                    last2_d = 1'b0;
                    hold_d  = HW'(HOLD_CYCLES - 24'd1);
                end else if (g2) begin
                    state_d = GRANT2;
                    last2_d = 1'b1;
                    hold_d  = HW'(HOLD_CYCLES - 24'd1);
                end
            end
            GRANT1, GRANT2: begin
                if (hold_q == '0) begin
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYCLES - 20'd1);
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // the owner's own re-press during its grant is dropped
        pend_d[0] = (pend_q[0] & ~g1) |
                    (evt1 & (state_q != GRANT1));
        pend_d[1] = (pend_q[1] & ~g2) |
                    (evt2 & (state_q != GRANT2));
    end

    // Arbiter registers; BUT1 wins the first tie after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pend_q  <= 2'b00;
            hold_q  <= '0;
            gap_q   <= '0;
            last2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            last2_q <= last2_d;
        end
    end

    assign LED1  = (state_q == GRANT1);
    assign LED2  = (state_q == GRANT2);
    assign OWNER = LED1 ? OWN_B1 : (LED2 ? OWN_B2 : OWN_NONE);
    assign PEND  = pend_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: vector tables plus random
// stimulus against a cycle-level reference model.
module tb_led_arbiter;

    localparam int D = 4;
    localparam int H = 10;
    localparam int G = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       BUT1, BUT2;
    logic       LED1, LED2;
    logic [1:0] OWNER, PEND;

    always #5 CLK = ~CLK;

    led_arbiter #(
        .DEB_MAX     (15'd4),
        .HOLD_CYCLES (24'd10),
        .GAP_CYCLES  (20'd2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BUT1  (BUT1),
        .BUT2  (BUT2),
        .LED1  (LED1),
        .LED2  (LED2),
        .OWNER (OWNER),
        .PEND  (PEND)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: index 0 = BUT1, 1 = BUT2
    int m_pa[2], m_pb[2], m_st[2], m_run[2], m_pend[2];
    int m_mode;  // 0 idle, 1 granted, 2 gap
    int m_own;   // 1 or 2 while granted
    int m_rem;   // cycles left in grant/gap
    int m_last;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pa[k] = 1; m_pb[k] = 1; m_st[k] = 1;
            m_run[k] = 0; m_pend[k] = 0;
        end
        m_mode = 0; m_own = 0; m_rem = 0; m_last = 2;
    endtask

    task automatic model_step(input logic b1, input logic b2);
        int evt[2];
        int gnt[2];
        int inp[2];
        int pmode, pown, pick;
        inp[0] = int'(b1);
        inp[1] = int'(b2);
        for (int k = 0; k < 2; k++) begin
            evt[k] = 0;
            gnt[k] = 0;
            if (m_pb[k] != m_st[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin
                    m_st[k]  = m_pb[k];
                    m_run[k] = 0;
                    evt[k]   = (m_st[k] == 0) ? 1 : 0;
                end
            end else begin
                m_run[k] = 0;
            end
            m_pb[k] = m_pa[k];
            m_pa[k] = inp[k];
        end
        pmode = m_mode;
        pown  = m_own;
        if (m_mode == 0) begin
            if (m_pend[0] != 0 || m_pend[1] != 0) begin
                if (m_pend[0] != 0 && m_pend[1] != 0)
                    pick = (m_last == 1) ? 2 : 1;
                else
                    pick = (m_pend[0] != 0) ? 1 : 2;
                gnt[pick-1] = 1;
                m_mode = 1; m_own = pick;
                m_rem = H; m_last = pick;
            end
        end else if (m_mode == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_mode = 2; m_rem = G; m_own = 0;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = ((m_pend[k] != 0 && gnt[k] == 0) ||
                         (evt[k] != 0 &&
                          !(pmode == 1 && pown == k + 1)))
                        ? 1 : 0;
        end
    endtask

    function automatic logic [5:0] model_out();
        logic l1, l2;
        logic [1:0] own, pd;
        l1 = (m_mode == 1 && m_own == 1);
        l2 = (m_mode == 1 && m_own == 2);
        own = l1 ? 2'b01 : (l2 ? 2'b10 : 2'b00);
        pd  = {m_pend[1] != 0, m_pend[0] != 0};
        return {l1, l2, own, pd};
    endfunction

    function automatic logic [5:0] dut_out();
        return {LED1, LED2, OWNER, PEND};
    endfunction

    task automatic check(input string name,
                         input logic [5:0] act,
                         input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (LED1 LED2 OWNER PEND)",
                     name, act, exp);
        end
    endtask

    task automatic tick(input logic b1, input logic b2);
        BUT1 = b1;
        BUT2 = b2;
        @(posedge CLK);
        if (RST_N) model_step(b1, b2);
        else       model_reset();
        #1;
        check($sformatf("model@%0t", $time), dut_out(), model_out());
    endtask

    typedef struct {
        logic       b1;
        logic       b2;
        int         n;
        logic [5:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic b1, input logic b2,
                       input int n, input logic [5:0] exp);
        vec_t v;
        v.b1 = b1; v.b2 = b2; v.n = n; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            repeat (vq[i].n) tick(vq[i].b1, vq[i].b2);
            check($sformatf("%s[%0d]", tag, i), dut_out(), vq[i].exp);
        end
        vq.delete();
    endtask

    initial begin
        logic r1, r2;
        RST_N = 1'b0;
        BUT1  = 1'b1;
        BUT2  = 1'b1;
        model_reset();
        #3;
        check("rst_init", dut_out(), 6'b000000);
        tick(1, 1);
        tick(1, 1);
        RST_N = 1'b1;

        // 1: async reset with both pressed and pending
        add(0, 0, 6, 6'b000011);
        run_vecs("s1_pend");
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("s1_async", dut_out(), 6'b000000);
        repeat (15) tick(0, 0);
        check("s1_nogrant", dut_out(), 6'b000000);
        repeat (4) tick(1, 1);
        RST_N = 1'b1;

        // 2: single clean press
        add(0, 1, 5,  6'b000000);
        add(0, 1, 1,  6'b000001);
        add(0, 1, 1,  6'b100100);
        add(0, 1, 9,  6'b100100);
        add(0, 1, 1,  6'b000000);
        add(0, 1, 1,  6'b000000);
        add(0, 1, 1,  6'b000000);
        add(0, 1, 11, 6'b000000);
        add(1, 1, 10, 6'b000000);
        run_vecs("s2");

        // 3: bounce rejection
        add(0, 1, 3,  6'b000000);
        add(1, 1, 1,  6'b000000);
        add(0, 1, 3,  6'b000000);
        add(1, 1, 10, 6'b000000);
        run_vecs("s3");

        // 4: round robin after BUT1 was last served
        add(0, 0, 5,  6'b000000);
        add(0, 0, 1,  6'b000011);
        add(0, 0, 1,  6'b011001);
        add(0, 0, 9,  6'b011001);
        add(0, 0, 1,  6'b000001);
        add(0, 0, 1,  6'b000001);
        add(0, 0, 1,  6'b000001);
        add(0, 0, 1,  6'b100100);
        add(0, 0, 9,  6'b100100);
        add(0, 0, 1,  6'b000000);
        add(0, 0, 3,  6'b000000);
        add(1, 1, 10, 6'b000000);
        run_vecs("s4");

        // 5: owner re-press discarded, other latched
        add(0, 1, 5,  6'b000000);
        add(1, 1, 1,  6'b000001);
        add(1, 1, 1,  6'b100100);
        add(1, 1, 3,  6'b100100);
        add(0, 0, 5,  6'b100100);
        add(0, 0, 1,  6'b100110);
        add(0, 0, 1,  6'b000010);
        add(0, 0, 2,  6'b000010);
        add(0, 0, 1,  6'b011000);
        add(0, 0, 9,  6'b011000);
        add(0, 0, 3,  6'b000000);
        add(0, 0, 5,  6'b000000);
        add(1, 1, 10, 6'b000000);
        run_vecs("s5");

        // 6: reset in the middle of a BUT2 grant
        add(1, 0, 2, 6'b000000);
        add(0, 0, 4, 6'b000010);
        add(0, 0, 1, 6'b011000);
        add(0, 0, 1, 6'b011001);
        add(0, 0, 3, 6'b011001);
        run_vecs("s6_pre");
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("s6_async", dut_out(), 6'b000000);
        repeat (4) tick(1, 1);
        RST_N = 1'b1;
        add(1, 1, 20, 6'b000000);
        run_vecs("s6_post");

        // random button activity against the model
        r1 = 1'b1;
        r2 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            if ($urandom_range(0, 7) == 0) r2 = ~r2;
            tick(r1, r2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
